seq_divider: RTL and testbench
==============================

# seq_divider

Iterative radix-2 restoring divider that responds to the ALU's start/done division handshake. It computes the unsigned WIDTH-bit quotient and remainder in exactly WIDTH cycles after a start is accepted. It sits inside the execute-stage ALU, which does the sign fix-up for signed ops and stalls the pipeline while `done` is low.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width. Must be ≥ 2.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `start` input, 1 bit: request a division. Accepted only while `done`=1.
- `a` input, WIDTH bits: dividend, unsigned. Sampled on the accepting edge only.
- `b` input, WIDTH bits: divisor, unsigned. Sampled on the accepting edge only.
- `quo` output, WIDTH bits: quotient of the last completed division.
- `rem` output, WIDTH bits: remainder of the last completed division.
- `done` output, 1 bit: 1 = idle and results valid; 0 = division in progress.

## Operation
- States: IDLE (`done`=1) and BUSY (`done`=0). The state machine has no other states.
- IDLE with `start`=1: latch `a` into the dividend/quotient shift register and `b` into the divisor register. Clear the partial remainder. Set the iteration counter to 0. Go to BUSY.
- IDLE with `start`=0: hold all registers. `quo` and `rem` keep the previous result.
- BUSY, one step per cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Compute trial = shifted remainder − divisor, with WIDTH+1 bits.
  - If trial is non-negative, the remainder becomes trial and quotient LSB = 1. Otherwise keep the shifted remainder and set quotient LSB = 0.
  - Increment the counter.
- BUSY with counter = WIDTH−1: perform the final step and go to IDLE. `done` rises after that edge.
- `start` is ignored while BUSY. Operand changes after the accepting edge have no effect.
- Divide by zero needs no special path. The algorithm naturally gives `quo`=all ones and `rem`=`a`, which matches RISC-V DIVU/REMU. The ALU relies on this.
- `quo` and `rem` are driven straight from the working registers.
  - While BUSY they hold intermediate values and are not valid.
  - They are valid whenever `done`=1.

## Timing
- Reset values: state IDLE, `done`=1, `quo`=0, `rem`=0, counter=0.
- Reset asserted mid-division: abort immediately to the reset values. The partial result is discarded.
- Latency: the start is accepted on edge E0. `done` reads 0 after edges E0..E(WIDTH−1). `done`=1 and results are valid after edge E(WIDTH). For WIDTH=32 that is 32 cycles of `done`=0.
- Back-to-back operation: `start`=1 in the same cycle that `done` first reads 1 is accepted. There is no dead cycle between divisions.
- `start` held high continuously restarts the divider every WIDTH+1 edges. The ALU drops `start` after acceptance, so this does not happen in normal use.
- `done` is a registered output. It depends only on state, never combinationally on `start`.

## Structure
- The IDLE/BUSY state enum and the counter width ($clog2(WIDTH)) are local to the module.
- No new typedefs are needed in rv32i_types. The ALU's op encoding stays unchanged.
- One natural sub-module, `div_step`: a combinational single-iteration restore step. Its inputs are the remainder, dividend MSB and divisor. Its outputs are the next remainder and the quotient bit. This lets the step be unit-tested alone and later unrolled to radix-4.
- Expected size: about 120–160 lines including `div_step`.

## Test plan
- Basic division: `a`=100, `b`=7, pulse `start`. Require `done`=0 for exactly 32 cycles, then `quo`=14, `rem`=2, `done`=1.
- Full-range operands: `a`=0xFFFFFFFF, `b`=1 → `quo`=0xFFFFFFFF, `rem`=0. Then `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → `quo`=1, `rem`=0.
- Divide by zero and small dividend: `a`=0x12345678, `b`=0 → `quo`=0xFFFFFFFF, `rem`=0x12345678. Then `a`=5, `b`=9 → `quo`=0, `rem`=5.
- Operand and start isolation: start `a`=1000, `b`=10. On the next cycle change `a`/`b` to random values and pulse `start` again mid-operation. Require `quo`=100, `rem`=0 at the original 32-cycle mark and no restart.
- Back-to-back: assert `start` with `a`=50, `b`=3 in the cycle `done` rises after a prior division. Require `done` to fall the next edge, then `quo`=16, `rem`=2 after 32 more cycles.
- Async reset: assert `rst` between clock edges at cycle 10 of a division. Require `done`=1, `quo`=0, `rem`=0 immediately without waiting for a clock. After release, a fresh division 77/8 gives `quo`=9, `rem`=5.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider slice.
package seq_divider_pkg;

   // Native operand width of the execute-stage ALU datapath.
   localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done division handshake between the ALU (master) and the divider (slave).
interface seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic             done;

   modport master (output start, output a, output b,
                   input  quo,   input  rem, input  done);
   modport slave  (input  start, input  a, input  b,
                   output quo,   output rem, output done);
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// try to subtract the divisor, keep the difference when it is non-negative.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             msb_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // The partial remainder is always below the divisor, so the shifted value
   // is below 2*divisor and WIDTH+1 bits are enough for the sign of the trial.
   always_comb begin
      shifted = {rem_in, msb_in};
      trial   = shifted - {1'b0, divisor};
      q_bit   = ~trial[WIDTH];
      rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   end
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: WIDTH busy cycles per division,
// unsigned quotient/remainder, divide-by-zero yields all-ones / dividend.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic           clk,
   input logic           rst,
   seq_divider_if.slave  bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] rem_reg;     // partial remainder
   logic [WIDTH-1:0] quo_reg;     // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] div_reg;     // divisor captured at acceptance
   logic [CNT_W-1:0] cnt_reg;     // iteration index
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic             accept;

   assign accept = (state_reg == IDLE) && bus.start;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_reg),
      .msb_in  (quo_reg[WIDTH-1]),
      .divisor (div_reg),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // State register; reset aborts any division in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next state: accept a start while idle, leave BUSY after the last step.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (bus.start) state_next = BUSY;
         BUSY: if (cnt_reg == CNT_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Working registers: load operands on acceptance, iterate while busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_reg <= '0;
         quo_reg <= '0;
         div_reg <= '0;
         cnt_reg <= '0;
      end else if (accept) begin
         rem_reg <= '0;
         quo_reg <= bus.a;
         div_reg <= bus.b;
         cnt_reg <= '0;
      end else if (state_reg == BUSY) begin
         rem_reg <= step_rem;
         quo_reg <= {quo_reg[WIDTH-2:0], step_q};
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Outputs: done is decoded from the state register only; results come
   // straight from the working registers and are valid while done is high.
   always_comb begin
      bus.done = (state_reg == IDLE);
      bus.quo  = quo_reg;
      bus.rem  = rem_reg;
   end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, corner sequences,
// and random operands against an arithmetic reference model.
module tb_seq_divider;
   localparam int W = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] quo;
      logic [W-1:0] rem;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
      end
   endtask

   // Reference: plain unsigned division with the RISC-V divide-by-zero rule.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
      if (b == 0) begin
         q = '1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   // Present operands with start for one cycle; returns #1 after the accepting edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Count edges with done low until done reads 1 (bounded).
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!bus.done && cyc < 200) begin
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int           cyc;
      logic [W-1:0] ea;
      logic [W-1:0] eb;
      logic [W-1:0] eq;
      logic [W-1:0] er;

      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      vecs[0] = '{"basic",      32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1] = '{"max_by_1",   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
      vecs[2] = '{"max_by_max", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
      vecs[3] = '{"div_zero",   32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
      vecs[4] = '{"small_a",    32'd5,          32'd9,          32'd0,          32'd5};
      vecs[5] = '{"exact",      32'd1000,       32'd10,         32'd100,        32'd0};

      // Reset state
      #1;
      check("reset_done", {31'd0, bus.done}, 32'd1);
      check("reset_quo",  bus.quo, 32'd0);
      check("reset_rem",  bus.rem, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_done", {31'd0, bus.done}, 32'd1);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         launch(vecs[i].a, vecs[i].b);
         wait_done(cyc);
         check({vecs[i].name, "_latency"}, cyc, 32'd32);
         check({vecs[i].name, "_quo"}, bus.quo, vecs[i].quo);
         check({vecs[i].name, "_rem"}, bus.rem, vecs[i].rem);
         $display("vec %s: a=%0d b=%0d quo=%0d rem=%0d cycles=%0d",
                  vecs[i].name, vecs[i].a, vecs[i].b, bus.quo, bus.rem, cyc);
      end

      // Idle hold: results persist with start low
      repeat (3) @(posedge clk);
      #1;
      check("hold_quo", bus.quo, 32'd100);
      check("hold_rem", bus.rem, 32'd0);

      // Operand and start isolation while busy
      launch(32'd1000, 32'd10);
      @(negedge clk);
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      wait_done(cyc);
      check("isolate_latency", cyc + 1, 32'd32);
      check("isolate_quo", bus.quo, 32'd100);
      check("isolate_rem", bus.rem, 32'd0);
      $display("isolate: quo=%0d rem=%0d cycles=%0d", bus.quo, bus.rem, cyc + 1);

      // Back-to-back: start in the first cycle done reads 1
      launch(32'd20, 32'd4);
      wait_done(cyc);
      check("b2b_first_quo", bus.quo, 32'd5);
      bus.start = 1'b1;
      bus.a     = 32'd50;
      bus.b     = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("b2b_done_fell", {31'd0, bus.done}, 32'd0);
      wait_done(cyc);
      check("b2b_latency", cyc, 32'd32);
      check("b2b_quo", bus.quo, 32'd16);
      check("b2b_rem", bus.rem, 32'd2);
      $display("b2b: quo=%0d rem=%0d cycles=%0d", bus.quo, bus.rem, cyc);

      // Asynchronous reset mid-division, between clock edges
      launch(32'd123456, 32'd67);
      repeat (9) @(posedge clk);
      #2;
      check("pre_reset_busy", {31'd0, bus.done}, 32'd0);
      rst = 1'b1;
      #1;
      check("areset_done", {31'd0, bus.done}, 32'd1);
      check("areset_quo",  bus.quo, 32'd0);
      check("areset_rem",  bus.rem, 32'd0);
      $display("async reset: done=%0d quo=%0d rem=%0d", bus.done, bus.quo, bus.rem);
      @(negedge clk);
      rst = 1'b0;
      launch(32'd77, 32'd8);
      wait_done(cyc);
      check("post_reset_latency", cyc, 32'd32);
      check("post_reset_quo", bus.quo, 32'd9);
      check("post_reset_rem", bus.rem, 32'd5);
      $display("post reset: quo=%0d rem=%0d cycles=%0d", bus.quo, bus.rem, cyc);

      // Random operands against the reference model
      for (int i = 0; i < 40; i++) begin
         ea = $urandom;
         case ($urandom_range(0, 3))
            0:       eb = 32'($urandom_range(0, 15));
            1:       eb = $urandom >> $urandom_range(0, 31);
            default: eb = $urandom;
         endcase
         model(ea, eb, eq, er);
         launch(ea, eb);
         wait_done(cyc);
         check("rand_latency", cyc, 32'd32);
         check("rand_quo", bus.quo, eq);
         check("rand_rem", bus.rem, er);
         $display("rand %0d: a=0x%08h b=0x%08h quo=0x%08h rem=0x%08h", i, ea, eb, bus.quo, bus.rem);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
